// File: rtl/hc_operand_stack.sv
// hc_operand_stack: parametrised operand stack with occupancy tracking and sticky overflow/underflow flags.
// Define HC_STACK_SWAP_EN to enable the SWAP op (code 110); otherwise it is a NOP.
module hc_operand_stack #(
    parameter int W              = 8,
    parameter int DEPTH          = 8,
    parameter bit DISCARD_ON_OVF = 1'b1
) (
    input  logic                       clk,
    input  logic                       nReset,
    input  logic                       op_valid,
    input  logic [2:0]                 op,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top_a,
    output logic [W-1:0]               top_b,
    output logic [W-1:0]               top_c,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       zero,
    output logic                       err_ovf,
    output logic                       err_udf
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);
    logic [W-1:0] stk [DEPTH];
    logic [W-1:0] stk_n [DEPTH];
    logic [DW-1:0] depth_n;
    logic [W-1:0] push_val;
    logic ovf_n, udf_n, is_full, has1, has2;
    assign is_full  = depth == DMAX;
    assign has1     = depth >= DW'(1);
    assign has2     = depth >= DW'(2);
    assign push_val = (op == 3'b101) ? stk[0] : din;
    assign top_a    = stk[0];
    assign top_b    = stk[1];
    assign top_c    = stk[2];
    assign empty    = depth == '0;
    assign full     = is_full;
    assign zero     = stk[0] == '0;
    // Slots at or beyond depth are kept at zero, so shifts never expose stale data.
    always_comb begin
        stk_n   = stk;
        depth_n = depth;
        ovf_n   = err_ovf;
        udf_n   = err_udf;
        if (op_valid) begin
            case (op)
                3'b001, 3'b101: begin
                    if (is_full) ovf_n = 1'b1;
                    if (!is_full || DISCARD_ON_OVF) begin
                        for (int i = 1; i < DEPTH; i++) stk_n[i] = stk[i-1];
                        stk_n[0] = push_val;
                        depth_n  = is_full ? depth : depth + DW'(1);
                    end
                end
                3'b010: begin
                    if (has1) begin
                        for (int i = 0; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
                        stk_n[DEPTH-1] = '0;
                        depth_n        = depth - DW'(1);
                    end else udf_n = 1'b1;
                end
                3'b011: begin
                    stk_n[0] = din;
                    if (!has1) begin
                        depth_n = DW'(1);
                        udf_n   = 1'b1;
                    end
                end
                3'b100: begin
                    if (has2) begin
                        for (int i = 1; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
                        stk_n[DEPTH-1] = '0;
                        stk_n[0]       = din;
                        depth_n        = depth - DW'(1);
                    end else udf_n = 1'b1;
                end
`ifdef HC_STACK_SWAP_EN
                3'b110: begin
                    if (has2) begin
                        stk_n[0] = stk[1];
                        stk_n[1] = stk[0];
                    end else udf_n = 1'b1;
                end
`endif
                3'b111: begin
                    for (int i = 0; i < DEPTH; i++) stk_n[i] = '0;
                    depth_n = '0;
                    ovf_n   = 1'b0;
                    udf_n   = 1'b0;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
            depth   <= '0;
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            stk     <= stk_n;
            depth   <= depth_n;
            err_ovf <= ovf_n;
            err_udf <= udf_n;
        end
    end
endmodule
